// File: rtl/sha_1_pkg.sv
// sha_1_pkg: shared types, constants and block packing for the SHA-1 front end.
package sha_1_pkg;

    typedef enum logic [1:0] {FILL, PAD, LENBLK, EMIT} pad_state_t;

    localparam int BLOCK_BYTES = 64;
    localparam int LEN_OFFSET = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef logic [31:0] sha_word_t;
    typedef logic [BLOCK_BYTES-1:0][7:0] block_bytes_t;
    typedef sha_word_t [15:0] block_words_t;

    function automatic block_words_t pack_words(input block_bytes_t b);
        block_words_t w;
        for (int i = 0; i < 16; i++) begin
            w[i] = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
        end
        return w;
    endfunction

endpackage

// File: rtl/sha_1_padder.sv
// sha_1_padder: byte-stream to SHA-1 padded 512-bit blocks with final-block flag.
module sha_1_padder
    import sha_1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic               in_empty,
    output logic               in_ready,
    output sha_word_t [15:0]   blk_data,
    output logic               blk_valid,
    output logic               blk_last,
    input  logic               blk_ready
);

    pad_state_t   state_q, state_d;
    block_bytes_t buf_q, buf_d;
    logic [5:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic pend_q, pend_d, last_q, last_d, lenblk_q, lenblk_d;
    logic [63:0]  len64;

    assign len64     = 64'(len_q);
    assign in_ready  = state_q == FILL;
    assign blk_valid = state_q == EMIT;
    assign blk_last  = last_q;
    assign blk_data  = pack_words(buf_q);

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        pend_d   = pend_q;
        last_d   = last_q;
        lenblk_d = lenblk_q;
        unique case (state_q)
            FILL: begin
                if (in_valid && !in_empty) begin
                    buf_d[ptr_q] = in_data;
                    ptr_d        = ptr_q + 6'd1;
                    len_d        = len_q + LEN_W'(8);
                    if (ptr_q == 6'd63) begin
                        state_d  = EMIT;
                        last_d   = 1'b0;
                        lenblk_d = 1'b0;
                        pend_d   = in_last;
                    end else if (in_last) begin
                        state_d = PAD;
                    end
                end else if (in_valid && in_last) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                // Length fits behind the marker only if the marker lands at byte 55 or earlier
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    buf_d[i] = (i < int'(ptr_q)) ? buf_q[i] :
                               (i == int'(ptr_q)) ? PAD_BYTE :
                               (int'(ptr_q) < LEN_OFFSET && i >= LEN_OFFSET) ? len64[(63-i)*8 +: 8] : 8'h00;
                end
                last_d   = int'(ptr_q) < LEN_OFFSET;
                lenblk_d = int'(ptr_q) >= LEN_OFFSET;
                state_d  = EMIT;
            end
            LENBLK: begin
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    buf_d[i] = (i >= LEN_OFFSET) ? len64[(63-i)*8 +: 8] : 8'h00;
                end
                last_d   = 1'b1;
                lenblk_d = 1'b0;
                state_d  = EMIT;
            end
            EMIT: begin
                if (blk_ready) begin
                    if (pend_q) begin
                        state_d = PAD;
                        ptr_d   = '0;
                        pend_d  = 1'b0;
                    end else if (lenblk_q) begin
                        state_d = LENBLK;
                    end else begin
                        state_d = FILL;
                        ptr_d   = '0;
                        len_d   = last_q ? '0 : len_q;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            buf_q    <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
            pend_q   <= 1'b0;
            last_q   <= 1'b0;
            lenblk_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            lenblk_q <= lenblk_d;
        end
    end

endmodule

// File: tb/tb_sha_1_padder.sv
// tb_sha_1_padder: directed self-checking bench for the SHA-1 padder.
module tb_sha_1_padder;
    import sha_1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0;
    logic in_ready;
    sha_word_t [15:0] blk_data;
    logic blk_valid, blk_last;
    logic blk_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    sha_word_t [15:0] exp_blk;

    sha_1_padder #(.LEN_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_empty(in_empty),
        .in_ready(in_ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input logic empty);
        int n = 0;
        in_data = b;
        in_last = last;
        in_empty = empty;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic send_msg(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) send(v, i == n - 1, 1'b0);
    endtask

    task automatic wait_blk(input string tag, input int exp_lat);
        int n = 0;
        while (!blk_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic take(input string tag, input logic exp_last, input int hold);
        for (int i = 0; i < 16; i++) check($sformatf("%s_w%0d", tag, i), blk_data[i], exp_blk[i]);
        check({tag, "_last"}, 32'(blk_last), 32'(exp_last));
        check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            checks++;
            assert (blk_data === exp_blk) else begin
                errors++;
                $error("FAIL %s_hold: got %h expected %h", tag, blk_data, exp_blk);
            end
            check({tag, "_hold_valid"}, 32'(blk_valid), 32'd1);
            check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1 blk_ready = 1'b0;
    endtask

    task automatic abc_case(input string tag);
        send(8'h61, 1'b0, 1'b0);
        send(8'h62, 1'b0, 1'b0);
        send(8'h63, 1'b1, 1'b0);
        wait_blk(tag, 1);
        exp_blk = '0;
        exp_blk[0] = 32'h61626380;
        exp_blk[15] = 32'h00000018;
        take(tag, 1'b1, 0);
        check({tag, "_done"}, 32'(blk_valid), 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_valid", 32'(blk_valid), 32'd0);
        check("rst_last", 32'(blk_last), 32'd0);
        check("rst_data_or", 32'(|blk_data), 32'd0);
        check("rst_inrdy", 32'(in_ready), 32'd1);

        abc_case("abc");

        send(8'h00, 1'b1, 1'b1);
        wait_blk("empty", 1);
        exp_blk = '0;
        exp_blk[0] = 32'h80000000;
        take("empty", 1'b1, 0);

        // A lone empty transfer without last is discarded and must not alter the next message
        send(8'hFF, 1'b0, 1'b1);
        send_msg(55, 8'h41);
        wait_blk("m55", 1);
        exp_blk = '0;
        for (int i = 0; i < 13; i++) exp_blk[i] = 32'h41414141;
        exp_blk[13] = 32'h41414180;
        exp_blk[15] = 32'h000001B8;
        take("m55", 1'b1, 0);

        send_msg(56, 8'h41);
        wait_blk("m56a", 1);
        exp_blk = '0;
        for (int i = 0; i < 14; i++) exp_blk[i] = 32'h41414141;
        exp_blk[14] = 32'h80000000;
        take("m56a", 1'b0, 0);
        wait_blk("m56b", 1);
        exp_blk = '0;
        exp_blk[15] = 32'h000001C0;
        take("m56b", 1'b1, 0);

        for (int i = 0; i < 64; i++) send(8'(i), i == 63, 1'b0);
        wait_blk("m64a", 0);
        for (int k = 0; k < 16; k++) exp_blk[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
        take("m64a", 1'b0, 5);
        wait_blk("m64b", 1);
        exp_blk = '0;
        exp_blk[0] = 32'h80000000;
        exp_blk[15] = 32'h00000200;
        take("m64b", 1'b1, 5);

        for (int i = 0; i < 64; i++) send(8'hAA, 1'b0, 1'b0);
        wait_blk("rst_emit", 0);
        do_reset();
        check("rst_emit_valid", 32'(blk_valid), 32'd0);
        check("rst_emit_inrdy", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) send(8'h5A, 1'b0, 1'b0);
        do_reset();
        abc_case("abc2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
